// File: rtl/fsm_pkg.sv
// Shared state encodings for the FIFO flow-control sequencer.
package fsm_pkg;

   typedef enum logic [2:0] {
      ST_RESET  = 3'd0,
      ST_INIT   = 3'd1,
      ST_IDLE   = 3'd2,
      ST_ACTIVE = 3'd3,
      ST_ERROR  = 3'd4
   } state_t;

endpackage

// File: rtl/prio_enc.sv
// Lowest-set-index encoder; returns 0 when no request bit is set.
module prio_enc #(
   parameter int N  = 5,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   output logic [IW-1:0] idx
);

   always_comb begin
      idx = '0;
      // Scan downward so the lowest set bit is the last (winning) write.
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) idx = IW'(i);
      end
   end

endmodule

// File: rtl/flow_ctrl_fsm.sv
// Flow-control sequencer: threshold load, idle/active tracking over a FIFO bank,
// and sticky error capture with explicit clear.
//
// state  | meaning
// RESET  | post-reset, unconditionally moves to INIT
// INIT   | thresholds reloaded every cycle, leaves when init drops
// IDLE   | all FIFOs empty
// ACTIVE | at least one FIFO recently non-empty
// ERROR  | FIFO error captured, waits for err_clr with errors gone
module flow_ctrl_fsm #(
   parameter int NUM_FIFOS = 5,
   parameter int TH_W      = 8,
   parameter int IDLE_HOLD = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         init,
   input  logic                         err_clr,
   input  logic [TH_W-1:0]              UMF,
   input  logic [TH_W-1:0]              UVC,
   input  logic [TH_W-1:0]              UD,
   input  logic [NUM_FIFOS-1:0]         FIFO_ERROR,
   input  logic [NUM_FIFOS-1:0]         FIFO_EMPTY,
   output logic [TH_W-1:0]              UMF_OUT,
   output logic [TH_W-1:0]              UVC_OUT,
   output logic [TH_W-1:0]              UD_OUT,
   output logic                         error_out,
   output logic                         active_out,
   output logic                         idle_out,
   output logic [$clog2(NUM_FIFOS)-1:0] error_id,
   output logic [NUM_FIFOS-1:0]         error_mask,
   output logic [2:0]                   state_out
);
   import fsm_pkg::*;

   localparam int IW = $clog2(NUM_FIFOS);
   localparam int CW = $clog2(IDLE_HOLD + 1);
   localparam logic [CW-1:0] HOLD_TC = CW'(IDLE_HOLD);

   state_t          state;
   state_t          state_nxt;
   logic [CW-1:0]   hold_cnt;
   logic [CW-1:0]   hold_inc;
   logic            hold_done;
   logic            any_err;
   logic            all_empty;
   logic [IW-1:0]   low_idx;
   logic            idle_nxt;
   logic            active_nxt;
   logic            error_nxt;

   assign any_err   = |FIFO_ERROR;
   assign all_empty = &FIFO_EMPTY;
   assign hold_inc  = (hold_cnt == HOLD_TC) ? hold_cnt : hold_cnt + CW'(1);
   assign hold_done = (hold_inc == HOLD_TC);
   assign state_out = state;

   prio_enc #(.N(NUM_FIFOS), .IW(IW)) u_prio_enc (
      .req (FIFO_ERROR),
      .idx (low_idx)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_RESET;
         idle_out   <= 1'b0;
         active_out <= 1'b0;
         error_out  <= 1'b0;
         hold_cnt   <= '0;
         UMF_OUT    <= '0;
         UVC_OUT    <= '0;
         UD_OUT     <= '0;
         error_id   <= '0;
         error_mask <= '0;
      end else begin
         state      <= state_nxt;
         idle_out   <= idle_nxt;
         active_out <= active_nxt;
         error_out  <= error_nxt;
         if (state_nxt != state || !all_empty) begin
            hold_cnt <= '0;
         end else if (state == ST_ACTIVE) begin
            hold_cnt <= hold_inc;
         end
         if (state == ST_INIT) begin
            UMF_OUT <= UMF;
            UVC_OUT <= UVC;
            UD_OUT  <= UD;
         end
         // Snapshot only on entry so a later partial clear cannot overwrite it.
         if (state_nxt == ST_ERROR && state != ST_ERROR) begin
            error_mask <= FIFO_ERROR;
            error_id   <= low_idx;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_RESET:  state_nxt = ST_INIT;
         ST_INIT: begin
            if (any_err)    state_nxt = ST_ERROR;
            else if (!init) state_nxt = ST_IDLE;
         end
         ST_IDLE: begin
            if (any_err)         state_nxt = ST_ERROR;
            else if (init)       state_nxt = ST_INIT;
            else if (!all_empty) state_nxt = ST_ACTIVE;
         end
         ST_ACTIVE: begin
            if (any_err)                     state_nxt = ST_ERROR;
            else if (init)                   state_nxt = ST_INIT;
            else if (all_empty && hold_done) state_nxt = ST_IDLE;
         end
         ST_ERROR: begin
            if (err_clr && !any_err) state_nxt = ST_INIT;
         end
         default:   state_nxt = ST_RESET;
      endcase
   end

   always_comb begin
      idle_nxt   = (state_nxt == ST_IDLE);
      active_nxt = (state_nxt == ST_ACTIVE);
      error_nxt  = (state_nxt == ST_ERROR);
   end

endmodule

// File: tb/tb_flow_ctrl_fsm.sv
// Directed scoreboard bench for flow_ctrl_fsm at default parameters.
module tb_flow_ctrl_fsm;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       init = 1'b1;
   logic       err_clr = 1'b0;
   logic [7:0] UMF = 8'h0A;
   logic [7:0] UVC = 8'h05;
   logic [7:0] UD  = 8'h03;
   logic [4:0] FIFO_ERROR = 5'b00000;
   logic [4:0] FIFO_EMPTY = 5'b11111;
   logic [7:0] UMF_OUT, UVC_OUT, UD_OUT;
   logic       error_out, active_out, idle_out;
   logic [2:0] error_id;
   logic [4:0] error_mask;
   logic [2:0] state_out;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [2:0] st;
      logic [7:0] umf;
      logic [7:0] uvc;
      logic [7:0] ud;
      logic [2:0] id;
      logic [4:0] mask;
   } exp_t;

   exp_t sb[$];

   flow_ctrl_fsm #(.NUM_FIFOS(5), .TH_W(8), .IDLE_HOLD(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .init       (init),
      .err_clr    (err_clr),
      .UMF        (UMF),
      .UVC        (UVC),
      .UD         (UD),
      .FIFO_ERROR (FIFO_ERROR),
      .FIFO_EMPTY (FIFO_EMPTY),
      .UMF_OUT    (UMF_OUT),
      .UVC_OUT    (UVC_OUT),
      .UD_OUT     (UD_OUT),
      .error_out  (error_out),
      .active_out (active_out),
      .idle_out   (idle_out),
      .error_id   (error_id),
      .error_mask (error_mask),
      .state_out  (state_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input string tag, input logic i_init, input logic i_clr,
                       input logic [4:0] fe, input logic [4:0] fem, input logic [2:0] st,
                       input logic [7:0] eu, input logic [7:0] ev, input logic [7:0] ed,
                       input logic [2:0] id, input logic [4:0] mask);
      exp_t e;
      exp_t got;
      init       = i_init;
      err_clr    = i_clr;
      FIFO_ERROR = fe;
      FIFO_EMPTY = fem;
      e.st = st; e.umf = eu; e.uvc = ev; e.ud = ed; e.id = id; e.mask = mask;
      sb.push_back(e);
      @(posedge clk);
      #1;
      got = sb.pop_front();
      chk({tag, " state"},  {29'd0, state_out}, {29'd0, got.st});
      chk({tag, " idle"},   {31'd0, idle_out},   {31'd0, got.st == 3'd2});
      chk({tag, " active"}, {31'd0, active_out}, {31'd0, got.st == 3'd3});
      chk({tag, " error"},  {31'd0, error_out},  {31'd0, got.st == 3'd4});
      chk({tag, " umf"},    {24'd0, UMF_OUT},    {24'd0, got.umf});
      chk({tag, " uvc"},    {24'd0, UVC_OUT},    {24'd0, got.uvc});
      chk({tag, " ud"},     {24'd0, UD_OUT},     {24'd0, got.ud});
      chk({tag, " id"},     {29'd0, error_id},   {29'd0, got.id});
      chk({tag, " mask"},   {27'd0, error_mask}, {27'd0, got.mask});
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " state"}, {29'd0, state_out}, 32'd0);
      chk({tag, " flags"}, {29'd0, idle_out, active_out, error_out}, 32'd0);
      chk({tag, " th"},    {8'd0, UMF_OUT, UVC_OUT, UD_OUT}, 32'd0);
      chk({tag, " id"},    {29'd0, error_id}, 32'd0);
      chk({tag, " mask"},  {27'd0, error_mask}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #3;
      chk_zero("rst");
      @(negedge clk);
      reset = 1'b1;
      //   tag    init clr  ferr      fempty    st    umf    uvc    ud     id    mask
      step("s01", 1'b1, 1'b0, 5'b00000, 5'b11111, 3'd1, 8'h00, 8'h00, 8'h00, 3'd0, 5'b00000);
      step("s02", 1'b1, 1'b0, 5'b00000, 5'b11111, 3'd1, 8'h0A, 8'h05, 8'h03, 3'd0, 5'b00000);
      step("s03", 1'b0, 1'b0, 5'b00000, 5'b11111, 3'd2, 8'h0A, 8'h05, 8'h03, 3'd0, 5'b00000);
      step("s04", 1'b0, 1'b0, 5'b00000, 5'b11011, 3'd3, 8'h0A, 8'h05, 8'h03, 3'd0, 5'b00000);
      step("s05", 1'b0, 1'b0, 5'b00000, 5'b11111, 3'd3, 8'h0A, 8'h05, 8'h03, 3'd0, 5'b00000);
      step("s06", 1'b0, 1'b0, 5'b00000, 5'b11111, 3'd2, 8'h0A, 8'h05, 8'h03, 3'd0, 5'b00000);
      step("s07", 1'b0, 1'b0, 5'b00000, 5'b11011, 3'd3, 8'h0A, 8'h05, 8'h03, 3'd0, 5'b00000);
      step("s08", 1'b0, 1'b0, 5'b00000, 5'b11111, 3'd3, 8'h0A, 8'h05, 8'h03, 3'd0, 5'b00000);
      step("s09", 1'b0, 1'b0, 5'b00000, 5'b10111, 3'd3, 8'h0A, 8'h05, 8'h03, 3'd0, 5'b00000);
      step("s10", 1'b0, 1'b0, 5'b00000, 5'b11111, 3'd3, 8'h0A, 8'h05, 8'h03, 3'd0, 5'b00000);
      step("s11", 1'b0, 1'b0, 5'b00000, 5'b11111, 3'd2, 8'h0A, 8'h05, 8'h03, 3'd0, 5'b00000);
      step("s12", 1'b0, 1'b0, 5'b00000, 5'b11110, 3'd3, 8'h0A, 8'h05, 8'h03, 3'd0, 5'b00000);
      step("s13", 1'b0, 1'b0, 5'b10100, 5'b11110, 3'd4, 8'h0A, 8'h05, 8'h03, 3'd2, 5'b10100);
      step("s14", 1'b0, 1'b1, 5'b00100, 5'b11111, 3'd4, 8'h0A, 8'h05, 8'h03, 3'd2, 5'b10100);
      UMF = 8'h11; UVC = 8'h22; UD = 8'h33;
      step("s15", 1'b1, 1'b1, 5'b00000, 5'b11111, 3'd1, 8'h0A, 8'h05, 8'h03, 3'd2, 5'b10100);
      step("s16", 1'b0, 1'b0, 5'b00000, 5'b11111, 3'd2, 8'h11, 8'h22, 8'h33, 3'd2, 5'b10100);
      step("s17", 1'b1, 1'b0, 5'b00001, 5'b11111, 3'd4, 8'h11, 8'h22, 8'h33, 3'd0, 5'b00001);
      step("s18", 1'b1, 1'b0, 5'b00000, 5'b11111, 3'd4, 8'h11, 8'h22, 8'h33, 3'd0, 5'b00001);
      step("s19", 1'b0, 1'b1, 5'b00000, 5'b11111, 3'd1, 8'h11, 8'h22, 8'h33, 3'd0, 5'b00001);
      step("s20", 1'b0, 1'b0, 5'b00000, 5'b11111, 3'd2, 8'h11, 8'h22, 8'h33, 3'd0, 5'b00001);
      step("s21", 1'b1, 1'b0, 5'b00000, 5'b00000, 3'd1, 8'h11, 8'h22, 8'h33, 3'd0, 5'b00001);
      step("s22", 1'b0, 1'b0, 5'b00000, 5'b00000, 3'd2, 8'h11, 8'h22, 8'h33, 3'd0, 5'b00001);
      step("s23", 1'b0, 1'b0, 5'b00000, 5'b00000, 3'd3, 8'h11, 8'h22, 8'h33, 3'd0, 5'b00001);
      step("s24", 1'b1, 1'b0, 5'b00000, 5'b00000, 3'd1, 8'h11, 8'h22, 8'h33, 3'd0, 5'b00001);
      step("s25", 1'b0, 1'b0, 5'b00000, 5'b00000, 3'd2, 8'h11, 8'h22, 8'h33, 3'd0, 5'b00001);
      step("s26", 1'b0, 1'b0, 5'b00000, 5'b00000, 3'd3, 8'h11, 8'h22, 8'h33, 3'd0, 5'b00001);
      step("s27", 1'b1, 1'b0, 5'b01000, 5'b00000, 3'd4, 8'h11, 8'h22, 8'h33, 3'd3, 5'b01000);
      step("s28", 1'b0, 1'b1, 5'b00000, 5'b11111, 3'd1, 8'h11, 8'h22, 8'h33, 3'd3, 5'b01000);
      step("s29", 1'b1, 1'b0, 5'b10000, 5'b11111, 3'd4, 8'h11, 8'h22, 8'h33, 3'd4, 5'b10000);
      step("s30", 1'b0, 1'b1, 5'b00000, 5'b11111, 3'd1, 8'h11, 8'h22, 8'h33, 3'd4, 5'b10000);
      step("s31", 1'b0, 1'b0, 5'b00000, 5'b11111, 3'd2, 8'h11, 8'h22, 8'h33, 3'd4, 5'b10000);
      step("s32", 1'b0, 1'b0, 5'b00000, 5'b00000, 3'd3, 8'h11, 8'h22, 8'h33, 3'd4, 5'b10000);
      #2;
      reset = 1'b0;
      #1;
      chk_zero("async");
      @(negedge clk);
      reset = 1'b1;
      step("s33", 1'b1, 1'b0, 5'b00000, 5'b11111, 3'd1, 8'h00, 8'h00, 8'h00, 3'd0, 5'b00000);
      step("s34", 1'b0, 1'b0, 5'b00000, 5'b11111, 3'd2, 8'h11, 8'h22, 8'h33, 3'd0, 5'b00000);
      chk("sb_empty", sb.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/flow_ctrl_fsm.md
FLOW_CTRL_FSM -- requirements
Module: flow_ctrl_fsm

Interface
REQ-001 SHALL have parameter NUM_FIFOS, default 5, number of monitored FIFOs (range 2..16).
REQ-002 SHALL have parameter TH_W, default 8, threshold width in bits.
REQ-003 SHALL have parameter IDLE_HOLD, default 2, consecutive all-empty cycles required for ACTIVE->IDLE (min 1).
REQ-004 SHALL have ports:
  clk  input  1  single clock, all state updates on rising edge
  reset  input  1  asynchronous, active-low reset
  init  input  1  request threshold (re)load
  err_clr  input  1  request exit from ERROR
  UMF  input  TH_W  main-FIFO threshold
  UVC  input  TH_W  virtual-channel threshold
  UD  input  TH_W  destination threshold
  FIFO_ERROR  input  NUM_FIFOS  per-FIFO error flags
  FIFO_EMPTY  input  NUM_FIFOS  per-FIFO empty flags
  UMF_OUT / UVC_OUT / UD_OUT  output  TH_W each  registered thresholds
  error_out / active_out / idle_out  output  1 each  state flags
  error_id  output  clog2(NUM_FIFOS)  lowest-index FIFO in error at ERROR entry
  error_mask  output  NUM_FIFOS  FIFO_ERROR snapshot at ERROR entry
  state_out  output  3  current state encoding

Function
REQ-005 SHALL implement states RESET, INIT, IDLE, ACTIVE, ERROR; all outputs registered (Moore).
REQ-006 RESET: unconditionally -> INIT on first rising edge after reset deasserts.
REQ-007 INIT: every cycle load UMF/UVC/UD into *_OUT; any FIFO_ERROR bit -> ERROR; else init low -> IDLE; else stay.
REQ-008 IDLE: priority FIFO_ERROR != 0 -> ERROR, then init -> INIT, then FIFO_EMPTY != all-ones -> ACTIVE, else stay.
REQ-009 ACTIVE: priority FIFO_ERROR != 0 -> ERROR, then init -> INIT, then IDLE_HOLD consecutive all-empty cycles -> IDLE.
REQ-010 Idle-hold counter SHALL clear on any cycle with a non-empty FIFO and on every state entry; width clog2(IDLE_HOLD+1), saturating.
REQ-011 ERROR: on entry capture error_mask = FIFO_ERROR and error_id = lowest set index; both hold until next ERROR entry or reset.
REQ-012 ERROR: err_clr high and FIFO_ERROR == 0 -> INIT; err_clr ignored while any FIFO_ERROR bit high; init ignored.
REQ-013 Flags: idle_out=1 only in IDLE, active_out=1 only in ACTIVE, error_out=1 only in ERROR; at most one high per cycle.
REQ-014 *_OUT SHALL hold last loaded value outside INIT, including across ERROR and ERROR->INIT.
REQ-015 Flags and state_out SHALL reflect the new state one cycle after the input condition is sampled.

Reset
REQ-016 On reset low, asynchronously: state=RESET, all flags 0, *_OUT=0, error_id=0, error_mask=0, idle counter=0.
REQ-017 Reset asserted mid-operation in any state SHALL abort immediately to RESET values; no captured data retained.

Structure
REQ-018 State encodings (RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4) SHALL live in shared package fsm_pkg.
REQ-019 Lowest-set-index encoder SHALL be sub-module prio_enc, parametrised on NUM_FIFOS.

Verification
REQ-020 Reset release, init=1 two cycles with UMF=8'h0A, UVC=8'h05, UD=8'h03, then init=0 -> state INIT then IDLE, *_OUT=0A/05/03, idle_out=1.
REQ-021 In IDLE, FIFO_EMPTY=5'b11011 one cycle -> ACTIVE; then all-ones for 2 cycles (IDLE_HOLD=2) -> IDLE; interrupted after 1 cycle -> stays ACTIVE.
REQ-022 In ACTIVE, FIFO_ERROR=5'b10100 -> ERROR, error_out=1, error_id=2, error_mask=5'b10100, *_OUT unchanged.
REQ-023 In ERROR, err_clr=1 with FIFO_ERROR=5'b00100 -> stays ERROR; FIFO_ERROR=0 plus err_clr=1 -> INIT, thresholds retained.
REQ-024 Same cycle FIFO_ERROR=5'b00001 and init=1 in IDLE -> ERROR, error_id=0.
REQ-025 Reset low asynchronously mid-ACTIVE (between edges) -> all outputs 0 and state_out=0 before next clk edge.
